sseg_scan_capture: RTL and testbench

Recovers the four BCD digits shown on a multiplexed, active-low 4-digit seven-segment display by watching the anode and segment lines. It is the receiving end of the display path: it decodes segment patterns back to BCD, filters scan-transition glitches, and presents a full 4-digit frame with per-digit error flags. It is used as an on-board self-check of the display driver and as a bench monitor for display-path verification.

---
 rtl/sseg_pkg.sv | 28 ++
 rtl/sseg_to_bcd.sv | 31 +++
 rtl/sseg_scan_capture.sv | 137 +++++++++++++
 tb/tb_sseg_scan_capture.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment scan capture block.
// Glyphs are active-low, bit 6 = a ... bit 0 = g.
package sseg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] DIGIT_ERR_CODE = 4'hF;

  typedef enum logic {SETTLE = 1'b0, HOLD = 1'b1} state_t;

  // True when exactly one anode strobe is driven low.
  function automatic logic is_onehot_low(input logic [3:0] an);
    logic [3:0] sel;
    sel = ~an;
    return (sel != 4'b0000) && ((sel & (sel - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/sseg_to_bcd.sv
// Combinational decoder from an active-low seven-segment glyph back to BCD.
// Anything outside the 0-9 glyph set reports the error code with valid low.
module sseg_to_bcd
  import sseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       valid
);

  // Glyph lookup table
  always_comb begin
    digit = DIGIT_ERR_CODE;
    valid = 1'b0;
    case (seg)
      SEG_0:     begin digit = 4'd0; valid = 1'b1; end
      SEG_1:     begin digit = 4'd1; valid = 1'b1; end
      SEG_2:     begin digit = 4'd2; valid = 1'b1; end
      SEG_3:     begin digit = 4'd3; valid = 1'b1; end
      SEG_4:     begin digit = 4'd4; valid = 1'b1; end
      SEG_5:     begin digit = 4'd5; valid = 1'b1; end
      SEG_6:     begin digit = 4'd6; valid = 1'b1; end
      SEG_7:     begin digit = 4'd7; valid = 1'b1; end
      SEG_8:     begin digit = 4'd8; valid = 1'b1; end
      SEG_9:     begin digit = 4'd9; valid = 1'b1; end
      SEG_BLANK: begin digit = DIGIT_ERR_CODE; valid = 1'b0; end
      default:   begin digit = DIGIT_ERR_CODE; valid = 1'b0; end
    endcase
  end

endmodule

// File: rtl/sseg_scan_capture.sv
// Watches a multiplexed active-low 4-digit display and rebuilds the shown
// BCD frame, filtering scan-transition glitches and flagging illegal glyphs.
module sseg_scan_capture
  import sseg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  sseg,
  output logic [15:0] bcd,
  output logic [3:0]  digit_err,
  output logic        frame_valid
);

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

  logic [10:0] sync1_r, sync2_r;
  logic [7:0]  cnt_r, cnt_nxt_s;
  state_t      state_r, state_nxt_s;
  logic        changed_s, capture_s, take_s, frame_done_s;
  logic [3:0]  an_s, dec_digit_s, sel_bit_s;
  logic        dec_valid_s;
  logic [1:0]  slot_s;
  logic [15:0] stage_r, stage_nxt_s, bcd_r;
  logic [3:0]  err_r, err_nxt_s, seen_r, seen_nxt_s, digit_err_r;
  logic        frame_valid_r;

  assign an_s      = sync2_r[10:7];
  // sync1 holds the sample that sync2 will take next, so it doubles as change lookahead
  assign changed_s = (sync1_r != sync2_r);

  sseg_to_bcd u_dec (
    .seg   (sync2_r[6:0]),
    .digit (dec_digit_s),
    .valid (dec_valid_s)
  );

  // Stability counter: restarts at 1 on any change of the synchronized sample
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (changed_s) begin
      cnt_nxt_s = 8'd1;
    end else if (cnt_r < STABLE_N) begin
      cnt_nxt_s = cnt_r + 8'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Capture FSM: one capture per stable period
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    case (state_r)
      SETTLE: begin
        if (cnt_r == STABLE_N) begin
          capture_s   = 1'b1;
          state_nxt_s = changed_s ? SETTLE : HOLD;
        end else begin
          state_nxt_s = SETTLE;
        end
      end
      HOLD: begin
        if (changed_s) begin
          state_nxt_s = SETTLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = SETTLE;
    endcase
  end

  // Staging update and frame-completion detection
  always_comb begin
    case (an_s)
      4'b1110: slot_s = 2'd0;
      4'b1101: slot_s = 2'd1;
      4'b1011: slot_s = 2'd2;
      4'b0111: slot_s = 2'd3;
      default: slot_s = 2'd0;
    endcase
    sel_bit_s    = 4'b0001 << slot_s;
    take_s       = capture_s && is_onehot_low(an_s);
    stage_nxt_s  = stage_r;
    err_nxt_s    = err_r;
    seen_nxt_s   = seen_r;
    frame_done_s = 1'b0;
    if (take_s) begin
      stage_nxt_s[{slot_s, 2'b00} +: 4] = dec_digit_s;
      err_nxt_s[slot_s]                 = ~dec_valid_s;
      seen_nxt_s                        = seen_r | sel_bit_s;
      frame_done_s                      = ((seen_r | sel_bit_s) == 4'b1111);
    end else begin
      frame_done_s = 1'b0;
    end
  end

  // Synchronizer, counter, FSM state and frame registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r       <= 11'h7FF;
      sync2_r       <= 11'h7FF;
      cnt_r         <= 8'd1;
      state_r       <= SETTLE;
      stage_r       <= 16'h0000;
      err_r         <= 4'b0000;
      seen_r        <= 4'b0000;
      bcd_r         <= 16'h0000;
      digit_err_r   <= 4'b0000;
      frame_valid_r <= 1'b0;
    end else begin
      sync1_r <= {an, sseg};
      sync2_r <= sync1_r;
      cnt_r   <= cnt_nxt_s;
      state_r <= state_nxt_s;
      stage_r <= stage_nxt_s;
      err_r   <= err_nxt_s;
      if (frame_done_s) begin
        bcd_r         <= stage_nxt_s;
        digit_err_r   <= err_nxt_s;
        seen_r        <= 4'b0000;
        frame_valid_r <= 1'b1;
      end else begin
        seen_r        <= seen_nxt_s;
        frame_valid_r <= 1'b0;
      end
    end
  end

  assign bcd         = bcd_r;
  assign digit_err   = digit_err_r;
  assign frame_valid = frame_valid_r;

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Self-checking bench for sseg_scan_capture: table-driven frames plus
// hand-written glitch, strobe and reset sequences, checked via a frame scoreboard.
module tb_sseg_scan_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic [15:0] bcd;
  logic [3:0]  digit_err;
  logic        frame_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  err;
  } exp_t;

  typedef struct {
    logic [6:0]  seg [4];
    logic [15:0] bcd;
    logic [3:0]  err;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[4];
  logic fv_prev = 1'b0;

  always #5 clk = ~clk;

  sseg_scan_capture #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an          (an),
    .sseg        (sseg),
    .bcd         (bcd),
    .digit_err   (digit_err),
    .frame_valid (frame_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every frame_valid pulse must match the oldest expected frame
  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      check("fv_consecutive", {31'd0, fv_prev}, 32'd0);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame actual bcd=%h err=%b required no frame", bcd, digit_err);
      end else begin
        mon_e = sb_q.pop_front();
        check("frame_bcd", {16'd0, bcd}, {16'd0, mon_e.bcd});
        check("frame_err", {28'd0, digit_err}, {28'd0, mon_e.err});
      end
    end
    fv_prev <= frame_valid;
  end

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an   = a;
    sseg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3);
    hold(4'b1110, s0, 10);
    hold(4'b1101, s1, 10);
    hold(4'b1011, s2, 10);
    hold(4'b0111, s3, 10);
  endtask

  task automatic expect_frame(input logic [15:0] b, input logic [3:0] e);
    exp_t x;
    x.bcd = b;
    x.err = e;
    sb_q.push_back(x);
  endtask

  task automatic drain(input string name);
    hold(4'b1111, 7'b1111111, 10);
    for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending_frames=%0d required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic set_vec(input int i, input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3,
                         input logic [15:0] b, input logic [3:0] e);
    vecs[i].seg[0] = s0;
    vecs[i].seg[1] = s1;
    vecs[i].seg[2] = s2;
    vecs[i].seg[3] = s3;
    vecs[i].bcd    = b;
    vecs[i].err    = e;
  endtask

  initial begin
    set_vec(0, 7'b0000110, 7'b0010010, 7'b1001111, 7'b1001100, 16'h4123, 4'b0000);
    set_vec(1, 7'b0000001, 7'b0000100, 7'b0000000, 7'b0001111, 16'h7890, 4'b0000);
    set_vec(2, 7'b0110000, 7'b0010010, 7'b1111111, 7'b1001100, 16'h4F2F, 4'b0101);
    set_vec(3, 7'b0100000, 7'b0100100, 7'b0000110, 7'b1001111, 16'h1356, 4'b0000);

    an    = 4'b1111;
    sseg  = 7'b1111111;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset_bcd", {16'd0, bcd}, 32'd0);
    check("reset_err", {28'd0, digit_err}, 32'd0);
    check("reset_fv", {31'd0, frame_valid}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(4'b1111, 7'b1111111, 5);

    for (int i = 0; i < 4; i++) begin
      expect_frame(vecs[i].bcd, vecs[i].err);
      scan(vecs[i].seg[0], vecs[i].seg[1], vecs[i].seg[2], vecs[i].seg[3]);
      drain("table_frame");
    end

    // Short 8 glitch at the end of digit1 must not replace the 2
    expect_frame(16'h4123, 4'b0000);
    hold(4'b1110, 7'b0000110, 10);
    hold(4'b1101, 7'b0010010, 10);
    hold(4'b1101, 7'b0000000, 3);
    hold(4'b1011, 7'b1001111, 10);
    hold(4'b0111, 7'b1001100, 10);
    drain("glitch3");

    // A 6-cycle dwell of 8 is long enough to be captured and overwrite the 2
    expect_frame(16'h4183, 4'b0000);
    hold(4'b1110, 7'b0000110, 10);
    hold(4'b1101, 7'b0010010, 10);
    hold(4'b1101, 7'b0000000, 6);
    hold(4'b1011, 7'b1001111, 10);
    hold(4'b0111, 7'b1001100, 10);
    drain("glitch6");

    // Illegal strobes carry a legal 8 glyph so any wrong capture corrupts a slot
    expect_frame(16'h4123, 4'b0000);
    hold(4'b1110, 7'b0000110, 10);
    hold(4'b1100, 7'b0000000, 20);
    hold(4'b1101, 7'b0010010, 10);
    hold(4'b1111, 7'b0000000, 20);
    hold(4'b1011, 7'b1001111, 10);
    hold(4'b0111, 7'b1001100, 10);
    drain("illegal_strobe");

    // Reset in the middle of a partial frame
    hold(4'b1110, 7'b0000001, 10);
    hold(4'b1101, 7'b0000001, 10);
    hold(4'b1011, 7'b0000001, 10);
    hold(4'b1111, 7'b1111111, 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_bcd", {16'd0, bcd}, 32'd0);
    check("midreset_err", {28'd0, digit_err}, 32'd0);
    check("midreset_fv", {31'd0, frame_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold(4'b1111, 7'b1111111, 5);
    expect_frame(16'h9765, 4'b0000);
    scan(7'b0100100, 7'b0100000, 7'b0001111, 7'b0000100);
    drain("post_reset_frame");
    check("final_bcd", {16'd0, bcd}, 32'h9765);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
